// File: rtl/oflow_calc_iou_if.sv
// Box-pair request and IoU result bundle for oflow_calc_iou.
interface oflow_calc_iou_if #(
   parameter int BBOX_POSITION_FRAME = 44,
   parameter int WIDTH_LEN           = 11,
   parameter int HEIGHT_LEN          = 11,
   parameter int IOU_LEN             = 12
);
   logic                           start;
   logic [BBOX_POSITION_FRAME-1:0] bbox_position_frame_k;
   logic [BBOX_POSITION_FRAME-1:0] bbox_position_frame_history;
   logic [WIDTH_LEN-1:0]           bbox_w_frame_k;
   logic [HEIGHT_LEN-1:0]          bbox_h_frame_k;
   logic [WIDTH_LEN-1:0]           bbox_w_frame_history;
   logic [HEIGHT_LEN-1:0]          bbox_h_frame_history;
   logic                           valid_iou;
   logic [IOU_LEN-1:0]             iou;

   modport master (
      output start, bbox_position_frame_k, bbox_position_frame_history,
             bbox_w_frame_k, bbox_h_frame_k, bbox_w_frame_history, bbox_h_frame_history,
      input  valid_iou, iou
   );

   modport slave (
      input  start, bbox_position_frame_k, bbox_position_frame_history,
             bbox_w_frame_k, bbox_h_frame_k, bbox_w_frame_history, bbox_h_frame_history,
      output valid_iou, iou
   );
endinterface

// File: rtl/oflow_calc_iou.sv
// oflow_calc_iou: IoU of two axis-aligned boxes as unsigned Q1.11.
// Sequence: capture -> intersection sides -> areas/union -> 12-step restoring divide -> publish.
module oflow_calc_iou #(
   parameter int POSITION_INTERSECTION = 11,
   parameter int BBOX_POSITION_FRAME   = 44,
   parameter int WIDTH_LEN             = 11,
   parameter int HEIGHT_LEN            = 11,
   parameter int IOU_LEN               = 12
) (
   input logic             clk,
   input logic             reset_N,
   oflow_calc_iou_if.slave bus
);
   localparam int P       = POSITION_INTERSECTION;
   localparam int INTER_W = 2 * P;
   localparam int AREA_W  = WIDTH_LEN + HEIGHT_LEN;
   localparam int UNION_W = ((AREA_W > INTER_W) ? AREA_W : INTER_W) + 1;
   localparam int REM_W   = UNION_W + 1;
   localparam int CNT_W   = $clog2(IOU_LEN);
   localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(IOU_LEN - 1);
   localparam logic [IOU_LEN-1:0] IOU_ONE   = {1'b1, {(IOU_LEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_INTER, S_UNION, S_DIV, S_DONE} state_e;

   state_e                         state_q, state_d;
   logic                           start_dly_q, start_dly_d;
   logic                           valid_q, valid_d;
   logic [IOU_LEN-1:0]             iou_q, iou_d;
   logic [BBOX_POSITION_FRAME-1:0] box_k_q, box_k_d, box_h_q, box_h_d;
   logic [WIDTH_LEN-1:0]           w_k_q, w_k_d, w_h_q, w_h_d;
   logic [HEIGHT_LEN-1:0]          h_k_q, h_k_d, h_h_q, h_h_d;
   logic [P-1:0]                   iw_q, iw_d, ih_q, ih_d;
   logic [INTER_W-1:0]             inter_q, inter_d;
   logic [UNION_W-1:0]             union_q, union_d;
   logic [REM_W-1:0]               rem_q, rem_d;
   logic [IOU_LEN-1:0]             quo_q, quo_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;

   logic [INTER_W-1:0] inter_prod;
   logic [AREA_W-1:0]  area_k, area_h;
   logic [UNION_W-1:0] union_sum;
   logic               div_take;
   logic [REM_W-1:0]   div_rem;

   // Overlap length of two 1-D spans; non-positive overlap clamps to zero.
   function automatic logic [P-1:0] overlap_len(input logic [P-1:0] lo_a, input logic [P-1:0] lo_b,
                                                input logic [P-1:0] hi_a, input logic [P-1:0] hi_b);
      logic [P-1:0] lo, hi;
      lo = (lo_a > lo_b) ? lo_a : lo_b;
      hi = (hi_a < hi_b) ? hi_a : hi_b;
      return (hi > lo) ? (hi - lo) : '0;
   endfunction

   // Empty overlap or empty union reads as 0; inconsistent boxes (inter > union) saturate at 1.0.
   function automatic logic [IOU_LEN-1:0] finalize_iou(input logic [INTER_W-1:0] inter,
                                                       input logic [UNION_W-1:0] uni,
                                                       input logic [IOU_LEN-1:0] q);
      if (uni == '0 || inter == '0)      return '0;
      else if (UNION_W'(inter) > uni)    return IOU_ONE;
      else                               return q;
   endfunction

   assign inter_prod = INTER_W'(iw_q) * INTER_W'(ih_q);
   assign area_k     = AREA_W'(w_k_q) * AREA_W'(h_k_q);
   assign area_h     = AREA_W'(w_h_q) * AREA_W'(h_h_q);
   assign union_sum  = UNION_W'(area_k) + UNION_W'(area_h) - UNION_W'(inter_prod);
   assign div_take   = (rem_q >= REM_W'(union_q));
   assign div_rem    = div_take ? (rem_q - REM_W'(union_q)) : rem_q;

   // Next-state and datapath updates for the capture/inter/union/divide/publish sequence.
   always_comb begin
      state_d     = state_q;
      start_dly_d = bus.start;
      valid_d     = 1'b0;
      iou_d       = iou_q;
      box_k_d     = box_k_q;
      box_h_d     = box_h_q;
      w_k_d       = w_k_q;
      h_k_d       = h_k_q;
      w_h_d       = w_h_q;
      h_h_d       = h_h_q;
      iw_d        = iw_q;
      ih_d        = ih_q;
      inter_d     = inter_q;
      union_d     = union_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !start_dly_q) begin
               box_k_d = bus.bbox_position_frame_k;
               box_h_d = bus.bbox_position_frame_history;
               w_k_d   = bus.bbox_w_frame_k;
               h_k_d   = bus.bbox_h_frame_k;
               w_h_d   = bus.bbox_w_frame_history;
               h_h_d   = bus.bbox_h_frame_history;
               state_d = S_INTER;
            end
         end
         S_INTER: begin
            // Packing is {X_TL, Y_TL, X_BR, Y_BR}, MSB first.
            iw_d    = overlap_len(box_k_q[4*P-1:3*P], box_h_q[4*P-1:3*P],
                                  box_k_q[2*P-1:P],   box_h_q[2*P-1:P]);
            ih_d    = overlap_len(box_k_q[3*P-1:2*P], box_h_q[3*P-1:2*P],
                                  box_k_q[P-1:0],     box_h_q[P-1:0]);
            state_d = S_UNION;
         end
         S_UNION: begin
            inter_d = inter_prod;
            union_d = union_sum;
            rem_d   = REM_W'(inter_prod);
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
         end
         S_DIV: begin
            // Remainder starts at inter, so the first step yields the integer (2^11) bit.
            quo_d = {quo_q[IOU_LEN-2:0], div_take};
            rem_d = {div_rem[REM_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) state_d = S_DONE;
         end
         S_DONE: begin
            iou_d   = finalize_iou(inter_q, union_q, quo_q);
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and visible outputs: reset returns to IDLE and discards any calculation.
   always_ff @(posedge clk) begin
      if (reset_N) begin
         state_q     <= S_IDLE;
         start_dly_q <= 1'b0;
         valid_q     <= 1'b0;
         iou_q       <= '0;
      end else begin
         state_q     <= state_d;
         start_dly_q <= start_dly_d;
         valid_q     <= valid_d;
         iou_q       <= iou_d;
      end
   end

   // Datapath registers; their contents only matter once the FSM has moved past IDLE.
   always_ff @(posedge clk) begin
      box_k_q <= box_k_d;
      box_h_q <= box_h_d;
      w_k_q   <= w_k_d;
      h_k_q   <= h_k_d;
      w_h_q   <= w_h_d;
      h_h_q   <= h_h_d;
      iw_q    <= iw_d;
      ih_q    <= ih_d;
      inter_q <= inter_d;
      union_q <= union_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
   end

   assign bus.valid_iou = valid_q;
   assign bus.iou       = iou_q;
endmodule

// File: tb/tb_oflow_calc_iou.sv
// Directed bench for oflow_calc_iou with an expected-result queue checked on valid_iou.
module tb_oflow_calc_iou;
   typedef struct { int xtl; int ytl; int xbr; int ybr; } box_t;
   typedef struct { int iou; int cyc; } exp_t;

   logic clk = 1'b0;
   logic reset_N;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t mon_e;

   oflow_calc_iou_if bus ();

   oflow_calc_iou dut (
      .clk     (clk),
      .reset_N (reset_N),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [43:0] pack_box(input box_t b);
      return {11'(b.xtl), 11'(b.ytl), 11'(b.xbr), 11'(b.ybr)};
   endfunction

   // Reference IoU straight from the box geometry.
   function automatic int ref_iou(input box_t k, input box_t h,
                                  input int wk, input int hk, input int wh, input int hh);
      int     iw, ih;
      longint inter, uni;
      iw = ((k.xbr < h.xbr) ? k.xbr : h.xbr) - ((k.xtl > h.xtl) ? k.xtl : h.xtl);
      ih = ((k.ybr < h.ybr) ? k.ybr : h.ybr) - ((k.ytl > h.ytl) ? k.ytl : h.ytl);
      if (iw < 0) iw = 0;
      if (ih < 0) ih = 0;
      inter = longint'(iw) * longint'(ih);
      uni   = (longint'(wk * hk) + longint'(wh * hh) - inter) & 64'h7F_FFFF;
      if (uni == 0 || inter == 0) return 0;
      if (inter > uni) return 2048;
      return int'((inter * 2048) / uni);
   endfunction

   task automatic drive_inputs(input box_t k, input box_t h,
                               input int wk, input int hk, input int wh, input int hh);
      bus.bbox_position_frame_k       = pack_box(k);
      bus.bbox_position_frame_history = pack_box(h);
      bus.bbox_w_frame_k              = 11'(wk);
      bus.bbox_h_frame_k              = 11'(hk);
      bus.bbox_w_frame_history        = 11'(wh);
      bus.bbox_h_frame_history        = 11'(hh);
   endtask

   // Raise start right after an edge; the next edge is the accepting edge E.
   task automatic launch(input box_t k, input box_t h,
                         input int wk, input int hk, input int wh, input int hh,
                         input int hold, input bit expect_out, output int e);
      exp_t x;
      @(posedge clk); #1;
      drive_inputs(k, h, wk, hk, wh, hh);
      bus.start = 1'b1;
      e = cyc + 1;
      if (expect_out) begin
         x.iou = ref_iou(k, h, wk, hk, wh, hh);
         x.cyc = e + 15;
         sb.push_back(x);
      end
      repeat (hold) @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL %s_timeout: pending=%0d required=0", tag, sb.size());
      end
      sb.delete();
   endtask

   task automatic check_hold(input string tag, input int v);
      repeat (2) @(negedge clk);
      n_tests++;
      assert (bus.iou === 12'(v)) else begin
         n_fail++;
         $error("FAIL %s: iou=%0d required=%0d", tag, bus.iou, v);
      end
      n_tests++;
      assert (bus.valid_iou === 1'b0) else begin
         n_fail++;
         $error("FAIL %s_valid_low: valid_iou=%b required=0", tag, bus.valid_iou);
      end
   endtask

   // Every valid_iou pulse must match the oldest outstanding expectation, value and cycle.
   always @(negedge clk) begin
      if (bus.valid_iou === 1'b1) begin
         n_tests++;
         assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_valid: valid_iou=1 at cycle %0d required=0", cyc);
         end
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            assert (bus.iou === 12'(mon_e.iou)) else begin
               n_fail++;
               $error("FAIL iou_value: iou=%0d required=%0d", bus.iou, mon_e.iou);
            end
            n_tests++;
            assert (cyc === mon_e.cyc) else begin
               n_fail++;
               $error("FAIL iou_latency: cycle=%0d required=%0d", cyc, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      box_t bk, bp, bnx, bdg;
      int   e, e2;
      bk  = '{50, 10, 60, 110};
      bp  = '{52,  8, 62, 108};
      bnx = '{70,  8, 80, 108};
      bdg = '{5, 5, 5, 5};

      reset_N   = 1'b1;
      bus.start = 1'b0;
      drive_inputs(bdg, bdg, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset_N = 1'b0;

      // Reset state
      @(negedge clk);
      n_tests++;
      assert (bus.iou === 12'd0) else begin
         n_fail++; $error("FAIL reset_iou: iou=%0d required=0", bus.iou);
      end
      n_tests++;
      assert (bus.valid_iou === 1'b0) else begin
         n_fail++; $error("FAIL reset_valid: valid_iou=%b required=0", bus.valid_iou);
      end

      // Partial overlap: inter 784, union 1216 -> 1320
      launch(bk, bp, 10, 100, 10, 100, 1, 1'b1, e);
      wait_drain("partial");
      check_hold("partial_hold", 1320);

      // No x-overlap
      launch(bk, bnx, 10, 100, 10, 100, 1, 1'b1, e);
      wait_drain("no_x_overlap");
      check_hold("no_x_overlap_hold", 0);

      // Identical boxes
      launch(bk, bk, 10, 100, 10, 100, 1, 1'b1, e);
      wait_drain("identical");
      check_hold("identical_hold", 2048);

      // Held start with inputs changed mid-calculation
      launch(bk, bp, 10, 100, 10, 100, 4, 1'b1, e);
      drive_inputs(bk, bnx, 3, 7, 9, 2);
      wait_drain("held_start");
      check_hold("held_start_hold", 1320);

      // Second start edge while busy is ignored; then back-to-back accept right after DONE
      launch(bk, bk, 10, 100, 10, 100, 1, 1'b1, e);
      wait_cycle(e + 5);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_cycle(e + 14);
      launch(bk, bnx, 10, 100, 10, 100, 1, 1'b1, e2);
      n_tests++;
      assert (e2 === e + 16) else begin
         n_fail++; $error("FAIL b2b_setup: accept_edge=%0d required=%0d", e2, e + 16);
      end
      wait_drain("busy_and_b2b");

      // Inconsistent sizes: inter 1000 > union 200 saturates
      launch(bk, bk, 6, 100, 6, 100, 1, 1'b1, e);
      wait_drain("saturate");
      check_hold("saturate_hold", 2048);

      // Reset in flight: no pulse, iou cleared, next start completes normally
      launch(bk, bp, 10, 100, 10, 100, 1, 1'b0, e);
      wait_cycle(e + 7);
      reset_N = 1'b1;
      @(posedge clk); #1 reset_N = 1'b0;
      @(negedge clk);
      n_tests++;
      assert (bus.iou === 12'd0) else begin
         n_fail++; $error("FAIL reset_mid_iou: iou=%0d required=0", bus.iou);
      end
      repeat (20) @(negedge clk);
      n_tests++;
      assert (bus.valid_iou === 1'b0 && bus.iou === 12'd0) else begin
         n_fail++; $error("FAIL reset_mid_quiet: valid_iou=%b iou=%0d required=0/0", bus.valid_iou, bus.iou);
      end
      launch(bk, bp, 10, 100, 10, 100, 1, 1'b1, e);
      wait_drain("after_reset");

      // Degenerate boxes
      launch(bdg, bdg, 0, 0, 0, 0, 1, 1'b1, e);
      wait_drain("degenerate");
      check_hold("degenerate_hold", 0);

      // Identical again, then zero union with nonzero overlap
      launch(bk, bk, 10, 100, 10, 100, 1, 1'b1, e);
      wait_drain("identical2");
      launch(bk, bk, 5, 100, 5, 100, 1, 1'b1, e);
      wait_drain("union_zero");
      check_hold("union_zero_hold", 0);

      // Start already high when reset releases counts as a rising edge
      @(posedge clk); #1;
      reset_N   = 1'b1;
      drive_inputs(bk, bp, 10, 100, 10, 100);
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_N = 1'b0;
      e = cyc + 1;
      mon_e.iou = ref_iou(bk, bp, 10, 100, 10, 100);
      mon_e.cyc = e + 15;
      sb.push_back(mon_e);
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b0;
      wait_drain("start_at_release");
      check_hold("start_at_release_hold", 1320);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
